// File: rtl/dcache_mem_ctrl_pkg.sv
// Shared widths and FSM encoding for the data-cache memory controller.
// Imported by the controller and its line assembler.
package dcache_mem_ctrl_pkg;

  localparam int WORD                = 32;
  localparam int CACHE_LINE_WIDTH    = 128;
  localparam int CACHE_LINE_BYTE_LOG = 4;

  typedef enum logic [1:0] {
    DCMC_IDLE  = 2'd0,
    DCMC_READ  = 2'd1,
    DCMC_WRITE = 2'd2,
    DCMC_DONE  = 2'd3
  } dcmc_state_e;

endpackage

// File: rtl/dcache_line_assembler.sv
// Beat counter plus line register filled one word per consumed read beat.
// Word k of the line lands in bits [32k+31:32k].
module dcache_line_assembler
  import dcache_mem_ctrl_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int BEAT_LOG   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       beat_we,
  input  logic [WORD-1:0]            mem_rdata,
  output logic [BEAT_LOG-1:0]        beat,
  output logic                       last_beat,
  output logic [LINE_WORDS*WORD-1:0] line
);

  logic [BEAT_LOG-1:0]        r_beat;
  logic [LINE_WORDS*WORD-1:0] r_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat <= '0;
      r_line <= '0;
    end else if (clr) begin
      r_beat <= '0;
    end else if (beat_we) begin
      r_line[r_beat*WORD +: WORD] <= mem_rdata;
      r_beat <= r_beat + 1'b1;
    end
  end

  assign beat      = r_beat;
  assign last_beat = (r_beat == BEAT_LOG'(LINE_WORDS-1));
  assign line      = r_line;

endmodule

// File: rtl/dcache_mem_ctrl.sv
// Services cache refills (4-beat burst) and write-through stores
// on a single word-wide req/ack memory port.
module dcache_mem_ctrl
  import dcache_mem_ctrl_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int BEAT_LOG   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dc_valid,
  input  logic                        dc_store,
  input  logic [WORD-1:0]             dc_addr,
  input  logic [WORD-1:0]             dc_wdata,
  output logic                        dc_ready,
  output logic [CACHE_LINE_WIDTH-1:0] dc_line,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [WORD-1:0]             mem_addr,
  output logic [WORD-1:0]             mem_wdata,
  input  logic [WORD-1:0]             mem_rdata,
  input  logic                        mem_ack
);

  dcmc_state_e r_state, w_next;

  logic [WORD-1:2]             r_addr;
  logic [WORD-1:0]             r_wdata;
  logic                        r_store;
  logic                        r_post_done;

  logic                        w_accept;
  logic                        w_clr;
  logic                        w_beat_we;
  logic                        w_req;
  logic                        w_ready;
  logic [BEAT_LOG-1:0]         w_beat;
  logic                        w_last;
  logic [CACHE_LINE_WIDTH-1:0] w_line;
  logic [WORD-1:0]             w_addr;

  dcache_line_assembler #(
    .LINE_WORDS (LINE_WORDS),
    .BEAT_LOG   (BEAT_LOG)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_clr),
    .beat_we   (w_beat_we),
    .mem_rdata (mem_rdata),
    .beat      (w_beat),
    .last_beat (w_last),
    .line      (w_line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= DCMC_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_store     <= 1'b0;
      r_post_done <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_post_done <= (r_state == DCMC_DONE);
      if (w_accept) begin
        r_addr  <= dc_addr[WORD-1:2];
        r_wdata <= dc_wdata;
        r_store <= dc_store;
      end
    end
  end

  // The cycle right after DONE still sees the old valid; never re-accept it.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_clr     = 1'b0;
    w_beat_we = 1'b0;
    w_req     = 1'b0;
    w_ready   = 1'b0;
    unique case (r_state)
      DCMC_IDLE: begin
        w_clr = 1'b1;
        if (dc_valid && !r_post_done) begin
          w_accept = 1'b1;
          w_next   = dc_store ? DCMC_WRITE : DCMC_READ;
        end
      end
      DCMC_READ: begin
        w_req = 1'b1;
        if (mem_ack) begin
          w_beat_we = 1'b1;
          if (w_last) w_next = DCMC_DONE;
        end
      end
      DCMC_WRITE: begin
        w_req = 1'b1;
        if (mem_ack) w_next = DCMC_DONE;
      end
      DCMC_DONE: begin
        w_ready = 1'b1;
        w_next  = DCMC_IDLE;
      end
      default: w_next = DCMC_IDLE;
    endcase
  end

  assign w_addr = r_store ? {r_addr, 2'b00}
                          : {r_addr[WORD-1:CACHE_LINE_BYTE_LOG], w_beat, 2'b00};

  assign dc_ready  = w_ready & ~rst;
  assign mem_req   = w_req & ~rst;
  assign mem_we    = w_req & r_store & ~rst;
  assign mem_addr  = rst ? '0 : w_addr;
  assign mem_wdata = rst ? '0 : r_wdata;
  assign dc_line   = rst ? '0 : w_line;

endmodule
